axil_io_regs: RTL
=================

# axil_io_regs

AXI4-Lite responder that terminates one crossbar master port (port 0, internal IO) with a bank of control (RW) and status (RO) registers. It accepts write address and write data independently, commits byte-masked writes, and returns single-beat read data and OKAY/SLVERR responses. The bank exposes control registers as flat vectors to core logic and samples status vectors from it.

## Interface
Parameters:
- ADDR_W, 32, AXI-Lite address width
- DATA_W, 32, data width (32 or 64)
- STRB_W, DATA_W/8, write strobe width
- NUM_RW, 8, number of control registers (1..64)
- NUM_RO, 4, number of status registers (0..64)
- CTRL_RST, 0, reset value of every control register (DATA_W bits)

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_wr_if  taxi_axil_if.wr_slv  —  awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready
- s_rd_if  taxi_axil_if.rd_slv  —  araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready
- ctrl_out  out  NUM_RW*DATA_W  control registers; register i at bits [i*DATA_W +: DATA_W]
- wr_pulse  out  NUM_RW  one-cycle strobe, bit i high in the cycle after register i commits
- status_in  in  NUM_RO*DATA_W  status words, sampled at AR handshake

## Operation
- Word index idx = addr[ADDR_W-1:log2(STRB_W)]; higher bits are not masked (crossbar decodes the window, so the full offset counts).
- idx < NUM_RW: control register idx (RW). NUM_RW ≤ idx < NUM_RW+NUM_RO: status word idx-NUM_RW (RO). Otherwise: unmapped.
- awprot/arprot ignored.
- Write path states: WR_IDLE, WR_RESP.
  - WR_IDLE: awready = !aw_held; wready = !w_held. Each handshake latches its channel into a hold register.
  - When AW and W are both held, or both handshake in one cycle, or one handshakes while the other is held: commit, move to WR_RESP.
  - Commit to a RW index: byte lanes with wstrb set are updated; bresp=OKAY (2'b00). Commit to a RO or unmapped index: no state change; bresp=SLVERR (2'b10).
  - WR_RESP: bvalid=1, awready=wready=0; on bvalid&&bready clear holds, return to WR_IDLE.
- Read path states: RD_IDLE, RD_RESP.
  - RD_IDLE: arready=1; on handshake capture data (control reg, status_in word, or 0) and rresp (OKAY for RW/RO, SLVERR for unmapped), move to RD_RESP.
  - RD_RESP: rvalid=1, arready=0, rdata/rresp stable; on rready return to RD_IDLE.
- Read and write paths are fully independent; no ordering between them.

## Timing
- Reset (async assert, sync release): awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, ctrl_out=all CTRL_RST, wr_pulse=0, FSMs idle, holds empty. Readies go to 1 in the first cycle after the first clock edge with aresetn high.
- Write latency: commit at the edge that completes the later of AW/W; in the next cycle bvalid=1, ctrl_out shows the new value, and wr_pulse[i]=1 (one cycle only, and only for OKAY writes to RW register i).
- Back-to-back: with bready held 1, bvalid stays high for one cycle; readies return the next cycle, so throughput is one write per 2 cycles.
- Read latency: rvalid=1 the cycle after the AR handshake. One read per 2 cycles with rready held 1.
- Simultaneous write commit and AR handshake on the same register at the same edge: the read returns the old value.
- Reset mid-transaction: all in-flight holds and responses are discarded; no B/R is issued afterward.
- No combinational paths from any input to any output; all outputs are registered.

## Configuration
- AXIL_IO_REGS_WSTRB_EN defined: per-byte wstrb masking as above.
- Not defined: wstrb ignored for data. Any nonzero wstrb writes the full word; wstrb==0 makes no change but still returns OKAY (wr_pulse still fires).

## Test plan
- AW+W same cycle, addr 0x04, wdata 0xDEADBEEF, wstrb 0xF, bready=1 -> bvalid 1 cycle later with bresp=00, ctrl_out reg1=0xDEADBEEF, wr_pulse=0x02 for one cycle.
- W 3 cycles before AW, addr 0x00, wdata 0x000000AA, wstrb 0x1 (after reg0=0x11223344) -> reg0=0x112233AA with WSTRB_EN; reg0=0x000000AA without it.
- Read addr 0x20 (NUM_RW=8) with status_in word0=0xCAFE0001 -> rvalid next cycle, rdata=0xCAFE0001, rresp=00. Write to 0x20 -> bresp=10, no ctrl change, wr_pulse=0.
- Read addr 0x40 -> rdata=0, rresp=10. bready/rready held low 5 cycles -> bvalid/rvalid and their payloads stay stable, and all readies stay 0.
- Write commit to reg2 at the same edge as an AR handshake to 0x08 -> rdata = old reg2, and a following read returns the new value.
- aresetn pulsed low while bvalid=1 -> bvalid=0 immediately, ctrl_out=CTRL_RST, no B response after release.

Source files
------------

// File: rtl/axil_io_regs_if.sv
// AXI4-Lite bus bundle split into write and read channel modports.
// Used by axil_io_regs and its bench; widths follow the instantiating scope.
interface taxi_axil_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport wr_slv (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
    modport rd_slv (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
    modport wr_mst (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport rd_mst (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_io_regs.sv
// AXI4-Lite control (RW) / status (RO) register bank with independent read and write paths.
// Optional build macro: AXIL_IO_REGS_WSTRB_EN enables per-byte write-strobe masking.
module axil_io_regs #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8,
    parameter int unsigned NUM_RW = 8,
    parameter int unsigned NUM_RO = 4,
    parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    taxi_axil_if.wr_slv              s_wr_if,
    taxi_axil_if.rd_slv              s_rd_if,
    output logic [NUM_RW*DATA_W-1:0] ctrl_out,
    output logic [NUM_RW-1:0]        wr_pulse,
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_W-1:0] status_in
);

    localparam int unsigned ALIGN = $clog2(STRB_W);
    localparam int unsigned IDX_W = ADDR_W - ALIGN;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdResp} rd_state_e;

    wr_state_e         wr_state_q;
    logic              aw_held_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              w_held_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [DATA_W-1:0] ctrl_q [NUM_RW];
    logic [NUM_RW-1:0] wr_pulse_q;

    rd_state_e         rd_state_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;

    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [DATA_W-1:0] wr_mask;
    logic              wr_is_rw;
    logic              ar_hs;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              rd_mapped;

    // Protection bits and sub-word address bits carry no meaning for this bank.
    logic unused_sigs;
    assign unused_sigs = ^{s_wr_if.awprot, s_rd_if.arprot,
                           s_wr_if.awaddr[ALIGN-1:0], s_rd_if.araddr[ALIGN-1:0]};

    // A channel arriving this cycle takes precedence over an empty hold register.
    assign aw_hs    = s_wr_if.awvalid && awready_q;
    assign w_hs     = s_wr_if.wvalid && wready_q;
    assign wr_idx   = aw_hs ? s_wr_if.awaddr[ADDR_W-1:ALIGN] : aw_idx_q;
    assign wr_data  = w_hs ? s_wr_if.wdata : w_data_q;
    assign wr_strb  = w_hs ? s_wr_if.wstrb : w_strb_q;
    assign commit   = (wr_state_q == WrIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_is_rw = wr_idx < IDX_W'(NUM_RW);

    always_comb begin
        wr_mask = '0;
`ifdef AXIL_IO_REGS_WSTRB_EN
        for (int unsigned b = 0; b < STRB_W; b++) begin
            wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
        end
`else
        wr_mask = {DATA_W{|wr_strb}};
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= WrIdle;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                ctrl_q[i] <= CTRL_RST;
            end
        end else begin
            wr_pulse_q <= '0;
            case (wr_state_q)
                WrIdle: begin
                    if (commit) begin
                        wr_state_q <= WrResp;
                        bvalid_q   <= 1'b1;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        if (wr_is_rw) begin
                            bresp_q <= RESP_OKAY;
                            for (int unsigned i = 0; i < NUM_RW; i++) begin
                                if (wr_idx == IDX_W'(i)) begin
                                    ctrl_q[i]     <= (ctrl_q[i] & ~wr_mask) | (wr_data & wr_mask);
                                    wr_pulse_q[i] <= 1'b1;
                                end
                            end
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            aw_idx_q  <= s_wr_if.awaddr[ADDR_W-1:ALIGN];
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            w_data_q <= s_wr_if.wdata;
                            w_strb_q <= s_wr_if.wstrb;
                        end
                        awready_q <= !(aw_held_q || aw_hs);
                        wready_q  <= !(w_held_q || w_hs);
                    end
                end
                WrResp: begin
                    if (s_wr_if.bready) begin
                        wr_state_q <= WrIdle;
                        bvalid_q   <= 1'b0;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ar_hs  = s_rd_if.arvalid && arready_q;
    assign rd_idx = s_rd_if.araddr[ADDR_W-1:ALIGN];

    // Read sees the pre-commit register value when a write lands on the same edge.
    always_comb begin
        rd_word   = '0;
        rd_mapped = 1'b0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word   = ctrl_q[i];
                rd_mapped = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_RO; j++) begin
            if (rd_idx == IDX_W'(NUM_RW + j)) begin
                rd_word   = status_in[j*DATA_W +: DATA_W];
                rd_mapped = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RdIdle: begin
                    if (ar_hs) begin
                        rd_state_q <= RdResp;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_word;
                        rresp_q    <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RdResp: begin
                    if (s_rd_if.rready) begin
                        rd_state_q <= RdIdle;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign s_wr_if.awready = awready_q;
    assign s_wr_if.wready  = wready_q;
    assign s_wr_if.bvalid  = bvalid_q;
    assign s_wr_if.bresp   = bresp_q;
    assign s_rd_if.arready = arready_q;
    assign s_rd_if.rvalid  = rvalid_q;
    assign s_rd_if.rresp   = rresp_q;
    assign s_rd_if.rdata   = rdata_q;
    assign wr_pulse        = wr_pulse_q;

    always_comb begin
        ctrl_out = '0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            ctrl_out[i*DATA_W +: DATA_W] = ctrl_q[i];
        end
    end

endmodule
